// File: rtl/branch_resolve_controller.sv
// rtl/branch_resolve_controller.sv - ID-stage branch hazard stall, resolve and performance counters
module branch_resolve_controller #(
    parameter int CNT_WIDTH  = 16,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  IsBranch,
    input  logic                  UsesRt,
    input  logic [REG_ADDR_W-1:0] Rs,
    input  logic [REG_ADDR_W-1:0] Rt,
    input  logic                  CmpTaken,
    input  logic                  EX_RegWrite,
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] EX_WriteReg,
    input  logic                  MEM_MemRead,
    input  logic [REG_ADDR_W-1:0] MEM_WriteReg,
    input  logic                  FlushIn,
    output logic                  Stall,
    output logic                  BranchTaken,
    output logic                  FlushIFID,
    output logic [CNT_WIDTH-1:0]  BranchCount,
    output logic [CNT_WIDTH-1:0]  TakenCount,
    output logic [CNT_WIDTH-1:0]  StallCount
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state_q, state_d;
    logic                 left_q, left_d;
    logic [CNT_WIDTH-1:0] branch_cnt_q, taken_cnt_q, stall_cnt_q;
    logic                 ex_match, mem_match;
    logic [1:0]           need;
    logic                 resolve;

    function automatic logic reg_match(input logic [REG_ADDR_W-1:0] r,
                                       input logic [REG_ADDR_W-1:0] rs,
                                       input logic [REG_ADDR_W-1:0] rt,
                                       input logic                  uses_rt);
        return (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        ex_match  = reg_match(EX_WriteReg, Rs, Rt, UsesRt);
        mem_match = reg_match(MEM_WriteReg, Rs, Rt, UsesRt);
        if (EX_RegWrite && EX_MemRead && ex_match)
            need = 2'd2;
        else if ((EX_RegWrite && ex_match) || (MEM_MemRead && mem_match))
            need = 2'd1;
        else
            need = 2'd0;
    end

    always_comb begin
        state_d     = state_q;
        left_d      = left_q;
        Stall       = 1'b0;
        resolve     = 1'b0;
        if (!Rst) begin
            state_d = IDLE;
            left_d  = 1'b0;
        end else if (FlushIn) begin
            state_d = IDLE;
            left_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (IsBranch) begin
                        if (need == 2'd0) begin
                            resolve = 1'b1;
                        end else begin
                            Stall   = 1'b1;
                            state_d = WAIT;
                            left_d  = (need == 2'd2);
                        end
                    end
                end
                WAIT: begin
                    // Losing the branch from ID while waiting abandons it silently.
                    if (!IsBranch) begin
                        state_d = IDLE;
                        left_d  = 1'b0;
                    end else if (left_q) begin
                        Stall  = 1'b1;
                        left_d = 1'b0;
                    end else begin
                        resolve = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    left_d  = 1'b0;
                end
            endcase
        end
        BranchTaken = resolve && CmpTaken;
        FlushIFID   = resolve && CmpTaken;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= IDLE;
            left_q       <= 1'b0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            if (resolve)
                branch_cnt_q <= sat_inc(branch_cnt_q);
            if (resolve && CmpTaken)
                taken_cnt_q <= sat_inc(taken_cnt_q);
            if (Stall)
                stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign BranchCount = branch_cnt_q;
    assign TakenCount  = taken_cnt_q;
    assign StallCount  = stall_cnt_q;

endmodule

// File: tb/tb_branch_resolve_controller.sv
// tb/tb_branch_resolve_controller.sv - scoreboard bench for branch_resolve_controller
module tb_branch_resolve_controller;
    localparam int CW   = 4;
    localparam int AW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          IsBranch = 1'b0, UsesRt = 1'b0, CmpTaken = 1'b0;
    logic [AW-1:0] Rs = '0, Rt = '0, EX_WriteReg = '0, MEM_WriteReg = '0;
    logic          EX_RegWrite = 1'b0, EX_MemRead = 1'b0, MEM_MemRead = 1'b0, FlushIn = 1'b0;
    logic          Stall, BranchTaken, FlushIFID;
    logic [CW-1:0] BranchCount, TakenCount, StallCount;

    branch_resolve_controller #(.CNT_WIDTH(CW), .REG_ADDR_W(AW)) dut (
        .Clk(Clk), .Rst(Rst), .IsBranch(IsBranch), .UsesRt(UsesRt), .Rs(Rs), .Rt(Rt),
        .CmpTaken(CmpTaken), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_WriteReg(EX_WriteReg), .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
        .FlushIn(FlushIn), .Stall(Stall), .BranchTaken(BranchTaken), .FlushIFID(FlushIFID),
        .BranchCount(BranchCount), .TakenCount(TakenCount), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit stall, taken, flush;
        int bc, tc, sc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference: a pending branch owes some number of stall cycles before it resolves.
    bit m_pending   = 0;
    int m_stalls    = 0;
    int m_bc = 0, m_tc = 0, m_sc = 0;

    function automatic bit hit(int r, int rs, int rt, bit ut);
        return (r != 0) && (r == rs || (ut && r == rt));
    endfunction

    task automatic step(input bit br, input bit ut, input int rs, input int rt, input bit cmp,
                        input bit exrw, input bit exmr, input int exwr,
                        input bit memmr, input int memwr, input bit fl, input bit rst_n);
        exp_t e;
        int   need;
        bit   res;
        @(posedge Clk);
        #1;
        IsBranch = br; UsesRt = ut; Rs = AW'(rs); Rt = AW'(rt); CmpTaken = cmp;
        EX_RegWrite = exrw; EX_MemRead = exmr; EX_WriteReg = AW'(exwr);
        MEM_MemRead = memmr; MEM_WriteReg = AW'(memwr); FlushIn = fl; Rst = rst_n;
        e.stall = 0; e.taken = 0; e.flush = 0;
        res = 0;
        if (!rst_n) begin
            m_pending = 0; m_bc = 0; m_tc = 0; m_sc = 0;
        end else if (fl) begin
            m_pending = 0;
        end else if (!m_pending) begin
            if (br) begin
                if (exrw && exmr && hit(exwr, rs, rt, ut)) need = 2;
                else if ((exrw && hit(exwr, rs, rt, ut)) || (memmr && hit(memwr, rs, rt, ut))) need = 1;
                else need = 0;
                if (need == 0) res = 1;
                else begin
                    e.stall = 1; m_pending = 1; m_stalls = need - 1;
                end
            end
        end else if (!br) begin
            m_pending = 0;
        end else if (m_stalls > 0) begin
            e.stall = 1; m_stalls--;
        end else begin
            res = 1; m_pending = 0;
        end
        e.taken = res && cmp;
        e.flush = res && cmp;
        e.bc = m_bc; e.tc = m_tc; e.sc = m_sc;
        exp_q.push_back(e);
        if (rst_n) begin
            if (res) m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
            if (res && cmp) m_tc = (m_tc < CMAX) ? m_tc + 1 : CMAX;
            if (e.stall) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", int'(Stall), int'(e.stall));
            chk("branch_taken", int'(BranchTaken), int'(e.taken));
            chk("flush_ifid", int'(FlushIFID), int'(e.flush));
            chk("branch_count", int'(BranchCount), e.bc);
            chk("taken_count", int'(TakenCount), e.tc);
            chk("stall_count", int'(StallCount), e.sc);
        end
    end

    initial begin
        int a, b;
        step(0,0,0,0,0, 0,0,0, 0,0, 0, 0);
        step(0,0,0,0,0, 0,0,0, 0,0, 0, 1);
        // no hazard, taken
        step(1,0,3,0,1, 1,0,7, 0,0, 0, 1);
        // ALU hazard then resolve not-taken
        step(1,0,5,0,0, 1,0,5, 0,0, 0, 1);
        step(1,0,5,0,0, 0,0,0, 0,0, 0, 1);
        // load-use on rt: two stalls, resolve on third
        step(1,1,2,9,1, 1,1,9, 0,0, 0, 1);
        step(1,1,2,9,1, 1,1,9, 0,0, 0, 1);
        step(1,1,2,9,1, 0,0,0, 0,0, 0, 1);
        // $0 never matches; rt ignored without UsesRt
        step(1,0,0,0,1, 1,1,0, 1,0, 0, 1);
        step(1,0,4,6,0, 1,1,6, 0,0, 0, 1);
        // MEM load hazard
        step(1,0,8,0,1, 0,0,0, 1,8, 0, 1);
        step(1,0,8,0,1, 0,0,0, 1,8, 0, 1);
        // abort via FlushIn from WAIT with one stall left
        step(1,0,5,0,1, 1,1,5, 0,0, 0, 1);
        step(1,0,5,0,1, 0,0,0, 0,0, 1, 1);
        step(0,0,0,0,0, 0,0,0, 0,0, 0, 1);
        // abort via IsBranch dropping in WAIT
        step(1,0,5,0,1, 1,0,5, 0,0, 0, 1);
        step(0,0,5,0,1, 0,0,0, 0,0, 0, 1);
        // async reset mid-WAIT
        step(1,0,5,0,1, 1,1,5, 0,0, 0, 1);
        step(1,0,5,0,1, 0,0,0, 0,0, 0, 0);
        step(1,0,5,0,1, 0,0,0, 0,0, 0, 1);
        // saturation: 2^CW+3 taken branches
        for (int i = 0; i < (1 << CW) + 3; i++)
            step(1,0,3,0,1, 0,0,0, 0,0, 0, 1);
        step(0,0,0,0,0, 0,0,0, 0,0, 0, 1);
        // randomized mix with small register space to provoke matches
        for (int i = 0; i < 3000; i++) begin
            a = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1), a, b, $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 199) != 0);
        end
        @(posedge Clk);
        @(negedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_resolve_controller.md
Name: branch_resolve_controller

Overview:
Sequences ID-stage branch resolution in the 5-stage MIPS pipeline. Detects when a branch's source registers are still being produced by instructions in EX or MEM, and stalls the front end for the required number of cycles. It then samples the branch comparator result, drives the PC-select and IF/ID flush, and keeps saturating performance counters.

Parameters:
CNT_WIDTH, 16, width of each performance counter
REG_ADDR_W, 5, register-address width

Ports:
Clk  in  1  clock, all state updates on the rising edge
Rst  in  1  asynchronous active-low reset
IsBranch  in  1  decoded conditional branch (beq/bne/blez/bgtz/bltz/bgez) is in ID
UsesRt  in  1  branch compares rt (beq/bne)
Rs  in  REG_ADDR_W  ID rs field
Rt  in  REG_ADDR_W  ID rt field
CmpTaken  in  1  branch comparator decision for the current ID operands
EX_RegWrite  in  1  EX instruction writes a register
EX_MemRead  in  1  EX instruction is a load
EX_WriteReg  in  REG_ADDR_W  EX destination register
MEM_MemRead  in  1  MEM instruction is a load
MEM_WriteReg  in  REG_ADDR_W  MEM destination register
FlushIn  in  1  pipeline flush from a jump or exception; aborts any pending branch
Stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
BranchTaken  out  1  select branch target for next PC
FlushIFID  out  1  squash the instruction in IF
BranchCount  out  CNT_WIDTH  resolved branches
TakenCount  out  CNT_WIDTH  resolved taken branches
StallCount  out  CNT_WIDTH  cycles with Stall=1

Behaviour:
- Match rule: match(r) = (r != 0) && (r == Rs || (UsesRt && r == Rt)).
- Required wait count, need, evaluated only in IDLE:
  - 2 if EX_RegWrite && EX_MemRead && match(EX_WriteReg).
  - else 1 if (EX_RegWrite && match(EX_WriteReg)) || (MEM_MemRead && match(MEM_WriteReg)).
  - else 0.
- State: {IDLE, WAIT} plus a 1-bit Left counter, all registered.
- IDLE, IsBranch && !FlushIn:
  - need=0: resolve this cycle, stay IDLE.
  - need=2: Stall=1, go to WAIT with Left=1.
  - need=1: Stall=1, go to WAIT with Left=0.
- WAIT, Left=1: Stall=1, Left becomes 0. Hazard inputs are ignored in WAIT.
- WAIT, Left=0: resolve this cycle, Stall=0, go to IDLE.
- Resolve cycle: BranchTaken=CmpTaken, FlushIFID=CmpTaken. BranchCount increments; TakenCount also increments if CmpTaken.
- Stall, BranchTaken and FlushIFID are combinational (Mealy) outputs from state and inputs. They are 0 in every cycle that is not a stall or resolve cycle.
- FlushIn=1, in any state:
  - Stall, BranchTaken and FlushIFID are forced to 0.
  - Next state is IDLE with Left=0.
  - No counter increments.
- IsBranch=0 while in WAIT is treated as an abort: go to IDLE with outputs 0 and no increments.
- StallCount increments on every cycle with Stall=1.
- All counters saturate at all-ones; they never wrap.
- Reset (Rst=0, asynchronous): state=IDLE, Left=0, all counters 0. Combinational outputs are 0 while reset is asserted. Reset asserted in the middle of a WAIT drops the pending branch.
- Back-to-back branches: the cycle after a resolve is IDLE, so a new branch in ID is evaluated fresh.

Test Plan:
1. No hazard: IsBranch=1, Rs=3, EX_WriteReg=7, CmpTaken=1 -> same cycle BranchTaken=1, FlushIFID=1, Stall=0; BranchCount=1, TakenCount=1.
2. ALU hazard: EX_RegWrite=1, EX_WriteReg=Rs=5 -> Stall=1 for exactly 1 cycle, then resolve with CmpTaken=0 -> BranchTaken=0; StallCount=1.
3. Load-use hazard: EX_MemRead=1, EX_RegWrite=1, EX_WriteReg=Rt=9, UsesRt=1 -> Stall=1 for 2 cycles, resolve on the 3rd cycle; StallCount=2.
4. Register $0 and unused rt: EX_WriteReg=0 matches Rs=0 -> no stall. EX_WriteReg=Rt with UsesRt=0 -> no stall.
5. Abort: enter WAIT with Left=1, assert FlushIn on the next cycle -> all outputs 0, next state IDLE, BranchCount unchanged. Separately, pulse Rst low mid-WAIT -> counters 0, Stall=0 immediately.
6. Saturation: preload by running 2^CNT_WIDTH+3 taken branches (CNT_WIDTH=4 build) -> BranchCount=TakenCount=15, holds at 15.
